// File: rtl/bcpu_alu_writeback_pkg.sv
// Purpose: shared types for the BCPU16 ALU result path (destination tag, ALU latency).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bcpu_defs;

    // CE-steps from ALU issue to ALU_RESULT/ALU_FLAGS valid.
    localparam int ALU_LATENCY     = 3;
    // Register index width carried in the tag; the top's REG_ADDR_WIDTH must match it.
    localparam int BCPU_REG_ADDR_W = 3;

    typedef struct packed {
        logic                       valid;
        logic                       reg_wb;
        logic                       flags_wb;
        logic [BCPU_REG_ADDR_W-1:0] dest;
    } alu_wb_tag_t;

endpackage

// File: rtl/bcpu_alu_tag_pipe.sv
// Purpose: CE-gated shift register of destination tags, kept in step with the ALU pipeline.
// Latency: ALU_LATENCY CE-steps from i_tag to the last stage; all stages are visible.
// Backpressure: i_ce=0 freezes every stage, exactly like the ALU.
module bcpu_alu_tag_pipe
    import bcpu_defs::*;
(
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_ce,
    input  alu_wb_tag_t                       i_tag,
    output alu_wb_tag_t [ALU_LATENCY-1:0]     o_stages
);

    // Index 0 is T1 (youngest), index ALU_LATENCY-1 is T3 (aligned with ALU output).
    alu_wb_tag_t [ALU_LATENCY-1:0] r_stages;

    // Shift one stage per enabled edge; reset discards everything in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stages <= '0;
        end else if (i_ce) begin
            r_stages <= {r_stages[ALU_LATENCY-2:0], i_tag};
        end
    end

    assign o_stages = r_stages;

endmodule

// File: rtl/bcpu_alu_writeback.sv
// Purpose: retire BCPU16 ALU results into regfile/flags and expose a register/flags scoreboard.
// Latency: write strobe is combinational in the CE cycle where the op's tag reaches T3.
// Backpressure: CE=0 holds all tags and suppresses the write; optional forwarding via BCPU_ALU_WB_BYPASS_EN.
module bcpu_alu_writeback
    import bcpu_defs::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = BCPU_REG_ADDR_W
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic                         CE,
    input  logic                         ALU_EN,
    input  logic [REG_ADDR_WIDTH-1:0]    DEST_REG_IN,
    input  logic                         REG_WB_IN,
    input  logic                         FLAGS_WB_IN,
    input  logic [DATA_WIDTH-1:0]        ALU_RESULT,
    input  logic [3:0]                   ALU_FLAGS,
`ifdef BCPU_ALU_WB_BYPASS_EN
    input  logic [REG_ADDR_WIDTH-1:0]    RD_ADDR,
    output logic                         BYPASS_HIT,
    output logic [DATA_WIDTH-1:0]        BYPASS_DATA,
    output logic [3:0]                   BYPASS_FLAGS,
`endif
    output logic                         REG_WR_EN,
    output logic [REG_ADDR_WIDTH-1:0]    REG_WR_ADDR,
    output logic [DATA_WIDTH-1:0]        REG_WR_DATA,
    output logic [3:0]                   FLAGS,
    output logic [2**REG_ADDR_WIDTH-1:0] BUSY_MASK,
    output logic                         FLAGS_PENDING
);

    // With forwarding, the T3 result is readable this cycle, so it no longer stalls issue.
`ifdef BCPU_ALU_WB_BYPASS_EN
    localparam int SB_DEPTH = ALU_LATENCY - 1;
`else
    localparam int SB_DEPTH = ALU_LATENCY;
`endif

    alu_wb_tag_t                     w_tag_in;
    alu_wb_tag_t [ALU_LATENCY-1:0]   w_stages;
    alu_wb_tag_t                     w_t3;
    logic                            w_retire;
    logic [2**REG_ADDR_WIDTH-1:0]    w_busy;
    logic                            w_flags_pend;
    logic [3:0]                      r_flags;

    assign w_tag_in = '{valid: ALU_EN, reg_wb: REG_WB_IN, flags_wb: FLAGS_WB_IN, dest: DEST_REG_IN};

    bcpu_alu_tag_pipe u_tag_pipe (
        .i_clk    (CLK),
        .i_rst_n  (RESET_N),
        .i_ce     (CE),
        .i_tag    (w_tag_in),
        .o_stages (w_stages)
    );

    assign w_t3     = w_stages[ALU_LATENCY-1];
    // The regfile samples on the same CE edge that advances T3, so each op writes exactly once.
    assign w_retire = w_t3.valid & CE;

    assign REG_WR_EN   = w_retire & w_t3.reg_wb;
    assign REG_WR_ADDR = w_t3.dest;
    assign REG_WR_DATA = ALU_RESULT;

    // Architectural flags update only when a flag-writing op retires.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_flags <= 4'b0000;
        end else if (w_retire && w_t3.flags_wb) begin
            r_flags <= ALU_FLAGS;
        end
    end

    assign FLAGS = r_flags;

    // Scoreboard: OR of one-hot destinations of every in-flight writer.
    always_comb begin
        w_busy       = '0;
        w_flags_pend = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (w_stages[i].valid && w_stages[i].reg_wb) begin
                w_busy[w_stages[i].dest] = 1'b1;
            end
            if (w_stages[i].valid && w_stages[i].flags_wb) begin
                w_flags_pend = 1'b1;
            end
        end
    end

    assign BUSY_MASK     = w_busy;
    assign FLAGS_PENDING = w_flags_pend;

`ifdef BCPU_ALU_WB_BYPASS_EN
    assign BYPASS_HIT   = w_t3.valid & w_t3.reg_wb & (w_t3.dest == RD_ADDR);
    assign BYPASS_DATA  = ALU_RESULT;
    assign BYPASS_FLAGS = (w_t3.valid && w_t3.flags_wb) ? ALU_FLAGS : r_flags;
`endif

endmodule
